logic_datapath: RTL
===================

// Module: logic_datapath
// PURPOSE
//  Register/compute/routing datapath driven by the lab2 control FSM outputs (Shift_En, Ld_A, Ld_B).
//  Holds operands A and B in WIDTH-bit right-shift registers.
//  Each shift cycle: applies bitwise function F to (A[0],B[0]); routes result/bits per R into both MSBs.
//  After WIDTH consecutive shifts the selected registers hold the full bitwise result.
// PARAMETERS
//  WIDTH  8  operand/register width in bits (>=2)
// PORTS
//  Clk       in   1      clock, all state updates on posedge
//  Reset     in   1      synchronous, active-high reset
//  Ld_A      in   1      load A from Din this cycle
//  Ld_B      in   1      load B from Din this cycle
//  Shift_En  in   1      shift A and B right one bit this cycle
//  Din       in   WIDTH  parallel load data (switches)
//  F         in   3      function select (see BEHAVIOUR)
//  R         in   2      routing select (see BEHAVIOUR)
//  A_out     out  WIDTH  contents of register A
//  B_out     out  WIDTH  contents of register B
//  Busy      out  1      1 while a shift sequence is in progress (shift count != 0)
//  Done      out  1      one-cycle pulse after the WIDTH-th consecutive shift
// BEHAVIOUR
//  Reset: A=0, B=0, shift count=0, Done=0, Busy=0, latched F/R=0. Reset overrides all other inputs.
//  Priority per cycle: Reset > load > shift > hold.
//  Load: Ld_A -> A<=Din; Ld_B -> B<=Din; both high -> both load Din.
//    Any load suppresses shifting of BOTH registers and clears the count.
//  Shift: f=F(A[0],B[0]); A<={A_in,A[WIDTH-1:1]}; B<={B_in,B[WIDTH-1:1]}.
//  F encoding: 000 AND, 001 OR, 010 XOR, 011 const 1, 100 NAND, 101 NOR, 110 XNOR, 111 const 0.
//  R routing (A_in,B_in):
//    00 -> (A[0],B[0])  rotate both, values preserved
//    01 -> (A[0],f)     result into B
//    10 -> (f,B[0])     result into A
//    11 -> (B[0],A[0])  swap
//  Counter: 0..WIDTH-1.
//    Increments on each shift cycle; wraps WIDTH-1 -> 0 on the WIDTH-th shift.
//    Cleared on any non-shift cycle (load or idle).
//  Done: registered; high exactly the one cycle after the clock edge that performs the WIDTH-th consecutive shift.
//    A shift run longer than WIDTH pulses Done again every WIDTH shifts.
//    A run shorter than WIDTH never pulses Done.
//  Busy: combinational (count != 0).
//  Latency: A_out/B_out are register outputs and reflect a load/shift on the next edge; no combinational path from inputs.
//  Reset mid-sequence: registers and count cleared immediately; no Done pulse.
// CONFIGURATION
//  LOGIC_DP_OPLATCH_EN defined:
//    F and R are captured into internal registers on the first shift of a sequence (count==0 && Shift_En).
//    The captured values are used for all WIDTH shifts of that sequence; switch changes mid-sequence are ignored.
//  LOGIC_DP_OPLATCH_EN undefined:
//    F and R are used live each shift cycle; no capture registers.
// STRUCTURE
//  Package logic_dp_pkg: enum func_e (F encodings above), enum route_e (R encodings), function apply_func(func_e,a,b).
//  Sub-module shift_reg_n #(WIDTH): sync reset, load, right shift with serial MSB input; instantiated twice (A, B).
//  Top holds compute/routing comb logic, shift counter, Done register, optional F/R latch.
// TESTING
//  1 Reset; Din=33 Ld_A; Din=55 Ld_B; F=000 R=10; 8 shifts -> A=11, B=55, Done high 1 cycle after 8th edge.
//  2 A=F0 B=0F; F=010 R=01; 8 shifts -> A=F0, B=FF; Busy high during shifts 1-7 only.
//  3 A=A5 B=3C; R=11; 8 shifts -> A=3C, B=A5; then R=00 F=any, 8 shifts -> unchanged.
//  4 A=A5 B=3C; 4 shifts then Reset -> A=00, B=00, Busy=0, Done never asserted.
//  5 Ld_A with Shift_En same cycle, Din=C3 -> A=C3, B unchanged, count=0.
//    3 shifts then idle, then 8 shifts -> single Done only after the 8.
//  6 With LOGIC_DP_OPLATCH_EN: A=FF B=0F, F=000 R=10, change F to 001 after shift 3 -> A=0F.
//    Without the macro -> A=FF (F=001 ORs bits 3..7, A=FF|0F=FF; low 3 bits F/F/F ANDed=1).

Source files
------------

// File: rtl/logic_dp_pkg.sv
// Shared types for the lab2 logic datapath: bitwise function and routing encodings.
package logic_dp_pkg;

  typedef enum logic [2:0] {
    F_AND  = 3'b000,
    F_OR   = 3'b001,
    F_XOR  = 3'b010,
    F_ONE  = 3'b011,
    F_NAND = 3'b100,
    F_NOR  = 3'b101,
    F_XNOR = 3'b110,
    F_ZERO = 3'b111
  } func_e;

  typedef enum logic [1:0] {
    R_ROT  = 2'b00,
    R_TO_B = 2'b01,
    R_TO_A = 2'b10,
    R_SWAP = 2'b11
  } route_e;

  function automatic logic apply_func(func_e fn, logic a, logic b);
    case (fn)
      F_AND:   return a & b;
      F_OR:    return a | b;
      F_XOR:   return a ^ b;
      F_ONE:   return 1'b1;
      F_NAND:  return ~(a & b);
      F_NOR:   return ~(a | b);
      F_XNOR:  return ~(a ^ b);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/logic_datapath_if.sv
// Control/data bundle between the lab2 control FSM (master) and the datapath (slave).
interface logic_datapath_if #(parameter int WIDTH = 8);
  logic             Ld_A;
  logic             Ld_B;
  logic             Shift_En;
  logic [WIDTH-1:0] Din;
  logic [2:0]       F;
  logic [1:0]       R;
  logic [WIDTH-1:0] A_out;
  logic [WIDTH-1:0] B_out;
  logic             Busy;
  logic             Done;

  modport master (
    output Ld_A, Ld_B, Shift_En, Din, F, R,
    input  A_out, B_out, Busy, Done
  );

  modport slave (
    input  Ld_A, Ld_B, Shift_En, Din, F, R,
    output A_out, B_out, Busy, Done
  );
endinterface

// File: rtl/logic_datapath_shift_reg_n.sv
// WIDTH-bit register with sync reset, parallel load and right shift with serial MSB input.
module shift_reg_n #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Load_i,
  input  logic             Shift_i,
  input  logic [WIDTH-1:0] D_i,
  input  logic             Sin_i,
  output logic [WIDTH-1:0] Q_o
);
  logic [WIDTH-1:0] q_q;

  always_ff @(posedge Clk) begin
    if (Reset)        q_q <= '0;
    else if (Load_i)  q_q <= D_i;
    else if (Shift_i) q_q <= {Sin_i, q_q[WIDTH-1:1]};
  end

  assign Q_o = q_q;
endmodule

// File: rtl/logic_datapath.sv
// Serial bitwise compute/route datapath; optional F/R capture per sequence via LOGIC_DP_OPLATCH_EN.
module logic_datapath
  import logic_dp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  logic_datapath_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] a_q, b_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q;
  logic             load, shift, last, f_bit, a_in, b_in;
  func_e            f_use;
  route_e           r_use;

  // A load on either register freezes both, so the pair never drifts out of step.
  assign load  = bus.Ld_A | bus.Ld_B;
  assign shift = bus.Shift_En & ~load;
  assign last  = (cnt_q == CW'(WIDTH - 1));

`ifdef LOGIC_DP_OPLATCH_EN
  func_e  f_q;
  route_e r_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      f_q <= F_AND;
      r_q <= R_ROT;
    end else if (shift && cnt_q == '0) begin
      f_q <= func_e'(bus.F);
      r_q <= route_e'(bus.R);
    end
  end

  // The first shift of a run uses the live switches it is capturing.
  assign f_use = (cnt_q == '0) ? func_e'(bus.F)  : f_q;
  assign r_use = (cnt_q == '0) ? route_e'(bus.R) : r_q;
`else
  assign f_use = func_e'(bus.F);
  assign r_use = route_e'(bus.R);
`endif

  assign f_bit = apply_func(f_use, a_q[0], b_q[0]);

  always_comb begin
    a_in = a_q[0];
    b_in = b_q[0];
    case (r_use)
      R_TO_B: b_in = f_bit;
      R_TO_A: a_in = f_bit;
      R_SWAP: begin
        a_in = b_q[0];
        b_in = a_q[0];
      end
      default: ;
    endcase
  end

  shift_reg_n #(.WIDTH(WIDTH)) u_reg_a (
    .Clk(Clk), .Reset(Reset), .Load_i(bus.Ld_A), .Shift_i(shift),
    .D_i(bus.Din), .Sin_i(a_in), .Q_o(a_q)
  );

  shift_reg_n #(.WIDTH(WIDTH)) u_reg_b (
    .Clk(Clk), .Reset(Reset), .Load_i(bus.Ld_B), .Shift_i(shift),
    .D_i(bus.Din), .Sin_i(b_in), .Q_o(b_q)
  );

  always_comb begin
    cnt_d = '0;
    if (shift && !last) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= shift & last;
    end
  end

  assign bus.A_out = a_q;
  assign bus.B_out = b_q;
  assign bus.Busy  = (cnt_q != '0);
  assign bus.Done  = done_q;
endmodule
